// File: rtl/aq_spsram_bist_pkg.sv
// Shared definitions for the single-port SRAM March C- self-test controller:
// FSM encoding, element indices and the per-element march table.
package aq_spsram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    localparam int ELEM_W = 3;

    localparam logic [ELEM_W-1:0] ELEM_E0 = 3'd0;
    localparam logic [ELEM_W-1:0] ELEM_E1 = 3'd1;
    localparam logic [ELEM_W-1:0] ELEM_E2 = 3'd2;
    localparam logic [ELEM_W-1:0] ELEM_E3 = 3'd3;
    localparam logic [ELEM_W-1:0] ELEM_E4 = 3'd4;
    localparam logic [ELEM_W-1:0] ELEM_E5 = 3'd5;

    // March table, one bit per element index (bit n = element En).
    // Bits 6 and 7 are unused padding so any 3-bit index is in range.
    //   E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 dn(r0,w1) E4 dn(r1,w0) E5 up(r0)
    localparam logic [7:0] MARCH_DIR_DOWN  = 8'b0001_1000;
    localparam logic [7:0] MARCH_RD_BG     = 8'b0001_0100;
    localparam logic [7:0] MARCH_WR_BG     = 8'b0000_1010;
    localparam logic [7:0] MARCH_HAS_READ  = 8'b0011_1110;
    localparam logic [7:0] MARCH_HAS_WRITE = 8'b0001_1111;

endpackage

// File: rtl/aq_spsram_bist_cmp.sv
// Read-data compare pipeline for the SRAM self-test: expected/valid stage,
// sticky fail flag and, with AQ_SPSRAM_BIST_DIAG_EN, first-failure capture.
module aq_spsram_bist_cmp
    import aq_spsram_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 32
`ifdef AQ_SPSRAM_BIST_DIAG_EN
    ,
    parameter int ADDR_WIDTH = 11
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  rd_en,
    input  logic                  rd_exp_bg,
`ifdef AQ_SPSRAM_BIST_DIAG_EN
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [ELEM_W-1:0]     rd_elem,
`endif
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  fail
`ifdef AQ_SPSRAM_BIST_DIAG_EN
    ,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [ELEM_W-1:0]     fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data
`endif
);

    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic                  vld_q, vld_d;
    logic                  fail_q, fail_d;
    logic                  mismatch;

    // ram_q for the read issued last cycle is valid now, so compare against
    // the expectation registered alongside that read.
    always_comb begin
        exp_d    = exp_q;
        vld_d    = rd_en & ~clear;
        if (rd_en) begin
            exp_d = {DATA_WIDTH{rd_exp_bg}};
        end
        mismatch = vld_q && (ram_q != exp_q);
        fail_d   = clear ? 1'b0 : (fail_q | mismatch);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q  <= '0;
            vld_q  <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            exp_q  <= exp_d;
            vld_q  <= vld_d;
            fail_q <= fail_d;
        end
    end

    assign fail = fail_q;

`ifdef AQ_SPSRAM_BIST_DIAG_EN
    logic [ADDR_WIDTH-1:0] pipe_addr_q, pipe_addr_d;
    logic [ELEM_W-1:0]     pipe_elem_q, pipe_elem_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [ELEM_W-1:0]     fail_elem_q, fail_elem_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;

    // Only the first mismatch of a run is kept; later ones leave it alone.
    always_comb begin
        pipe_addr_d = pipe_addr_q;
        pipe_elem_d = pipe_elem_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_data_d = fail_data_q;
        if (rd_en) begin
            pipe_addr_d = rd_addr;
            pipe_elem_d = rd_elem;
        end
        if (clear) begin
            fail_addr_d = '0;
            fail_elem_d = '0;
            fail_data_d = '0;
        end else if (mismatch && !fail_q) begin
            fail_addr_d = pipe_addr_q;
            fail_elem_d = pipe_elem_q;
            fail_data_d = ram_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_addr_q <= '0;
            pipe_elem_q <= '0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_data_q <= '0;
        end else begin
            pipe_addr_q <= pipe_addr_d;
            pipe_elem_q <= pipe_elem_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign fail_data = fail_data_q;
`endif

endmodule

// File: rtl/aq_spsram_bist_ctrl.sv
// March C- self-test initiator for a single-port SRAM wrapper (A/CEN/D/GWEN/WEN/Q).
// Define AQ_SPSRAM_BIST_DIAG_EN to add first-failure address/element/data outputs.
module aq_spsram_bist_ctrl
    import aq_spsram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  bist_start,
    output logic                  bist_busy,
    output logic                  bist_done,
    output logic                  bist_fail,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_cen,
    output logic                  ram_gwen,
    output logic [DATA_WIDTH-1:0] ram_wen,
    output logic [DATA_WIDTH-1:0] ram_d,
    input  logic [DATA_WIDTH-1:0] ram_q
`ifdef AQ_SPSRAM_BIST_DIAG_EN
    ,
    output logic [ADDR_WIDTH-1:0] bist_fail_addr,
    output logic [2:0]            bist_fail_elem,
    output logic [DATA_WIDTH-1:0] bist_fail_data
`endif
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    bist_state_e           state_q, state_d;
    logic [ELEM_W-1:0]     elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  phase_q, phase_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
    logic                  ram_cen_q, ram_cen_d;
    logic                  ram_gwen_q, ram_gwen_d;
    logic [DATA_WIDTH-1:0] ram_wen_q, ram_wen_d;
    logic [DATA_WIDTH-1:0] ram_d_q, ram_d_d;

    logic                  start_acc;
    logic                  cur_down;
    logic                  addr_last;
    logic [ELEM_W-1:0]     elem_inc;
    logic                  wr_d;
    logic                  rd_en;
    logic                  rd_exp_bg;

    // Sequencing: elem/addr/phase always name the access currently on the bus.
    // phase 0 is the read half and phase 1 the write half of a r/w pair.
    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        addr_d    = addr_q;
        phase_d   = phase_q;
        busy_d    = busy_q;
        done_d    = done_q;
        start_acc = 1'b0;
        elem_inc  = elem_q + 1'b1;
        cur_down  = MARCH_DIR_DOWN[elem_q];
        addr_last = cur_down ? (addr_q == '0) : (addr_q == ADDR_MAX);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bist_start) begin
                    start_acc = 1'b1;
                    state_d   = ST_RUN;
                    elem_d    = ELEM_E0;
                    addr_d    = MARCH_DIR_DOWN[ELEM_E0] ? ADDR_MAX : '0;
                    phase_d   = 1'b0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (MARCH_HAS_READ[elem_q] && MARCH_HAS_WRITE[elem_q] && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr_last) begin
                        if (elem_q == ELEM_E5) begin
                            state_d = ST_DRAIN;
                        end else begin
                            elem_d = elem_inc;
                            addr_d = MARCH_DIR_DOWN[elem_inc] ? ADDR_MAX : '0;
                        end
                    end else begin
                        addr_d = cur_down ? (addr_q - 1'b1) : (addr_q + 1'b1);
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The bus is decoded from the next sequencer values so the registered
    // ram_* outputs line up with the state they belong to.
    always_comb begin
        wr_d       = MARCH_HAS_WRITE[elem_d] && (!MARCH_HAS_READ[elem_d] || phase_d);
        ram_a_d    = '0;
        ram_cen_d  = 1'b1;
        ram_gwen_d = 1'b0;
        ram_wen_d  = '0;
        ram_d_d    = '0;
        if (state_d == ST_RUN) begin
            ram_a_d    = addr_d;
            ram_cen_d  = 1'b0;
            ram_gwen_d = wr_d;
            if (wr_d) begin
                ram_wen_d = '1;
                ram_d_d   = {DATA_WIDTH{MARCH_WR_BG[elem_d]}};
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= ST_IDLE;
            elem_q     <= '0;
            addr_q     <= '0;
            phase_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ram_a_q    <= '0;
            ram_cen_q  <= 1'b1;
            ram_gwen_q <= 1'b0;
            ram_wen_q  <= '0;
            ram_d_q    <= '0;
        end else begin
            state_q    <= state_d;
            elem_q     <= elem_d;
            addr_q     <= addr_d;
            phase_q    <= phase_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ram_a_q    <= ram_a_d;
            ram_cen_q  <= ram_cen_d;
            ram_gwen_q <= ram_gwen_d;
            ram_wen_q  <= ram_wen_d;
            ram_d_q    <= ram_d_d;
        end
    end

    assign rd_en     = ~ram_cen_q & ~ram_gwen_q;
    assign rd_exp_bg = MARCH_RD_BG[elem_q];

`ifdef AQ_SPSRAM_BIST_DIAG_EN
    aq_spsram_bist_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cmp (
        .clk       (forever_cpuclk),
        .rst_n     (cpurst_b),
        .clear     (start_acc),
        .rd_en     (rd_en),
        .rd_exp_bg (rd_exp_bg),
        .rd_addr   (ram_a_q),
        .rd_elem   (elem_q),
        .ram_q     (ram_q),
        .fail      (bist_fail),
        .fail_addr (bist_fail_addr),
        .fail_elem (bist_fail_elem),
        .fail_data (bist_fail_data)
    );
`else
    aq_spsram_bist_cmp #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .clk       (forever_cpuclk),
        .rst_n     (cpurst_b),
        .clear     (start_acc),
        .rd_en     (rd_en),
        .rd_exp_bg (rd_exp_bg),
        .ram_q     (ram_q),
        .fail      (bist_fail)
    );
`endif

    assign bist_busy = busy_q;
    assign bist_done = done_q;
    assign ram_a     = ram_a_q;
    assign ram_cen   = ram_cen_q;
    assign ram_gwen  = ram_gwen_q;
    assign ram_wen   = ram_wen_q;
    assign ram_d     = ram_d_q;

endmodule

// File: doc/aq_spsram_bist_ctrl.md
Name: aq_spsram_bist_ctrl

Overview:
Initiator-side controller for the single-port SRAM macro wrapper interface (A/CEN/D/GWEN/WEN/Q). It runs a March C- self-test over the whole array and compares the read data. It reports pass/fail to the test/CSR logic. It sits between the test-mode control and the functional-path mux in front of each 2048x32 SRAM instance.

Parameters:
ADDR_WIDTH, 11, SRAM address width; depth = 2^ADDR_WIDTH
DATA_WIDTH, 32, SRAM word width

Ports:
forever_cpuclk  input  1  clock; also drives the SRAM CLK
cpurst_b  input  1  asynchronous active-low reset
bist_start  input  1  one-cycle pulse that starts a run; ignored while busy
bist_busy  output  1  high while a run is in progress
bist_done  output  1  level; high from run end until the next accepted start
bist_fail  output  1  sticky mismatch flag; valid when bist_done is high
ram_a  output  ADDR_WIDTH  SRAM address
ram_cen  output  1  chip enable, active low
ram_gwen  output  1  global write enable, active high (1 = write)
ram_wen  output  DATA_WIDTH  bit write enables, active high
ram_d  output  DATA_WIDTH  write data
ram_q  input  DATA_WIDTH  read data; valid one cycle after the read access

Behaviour:
- Reset values: bist_busy=0, bist_done=0, bist_fail=0, ram_cen=1, ram_gwen=0, ram_wen=0, ram_a=0, ram_d=0. The run state and diag registers are cleared.
- All ram_* outputs are registered. The SRAM samples them on the next clock edge.
- FSM states: IDLE -> RUN (on bist_start) -> DRAIN -> DONE. DONE -> RUN on bist_start.
  - Accepting a start clears bist_fail, bist_done and the diag registers, and sets bist_busy the next cycle.
- March sequence. Background 0 = all zeros, 1 = all ones. Up = address 0..max, down = max..0.
  - E0: up (w0)
  - E1: up (r0, w1)
  - E2: up (r1, w0)
  - E3: down (r0, w1)
  - E4: down (r1, w0)
  - E5: up (r0)
- Each access takes one cycle with ram_cen=0.
  - Read: ram_gwen=0, ram_wen=0.
  - Write: ram_gwen=1, ram_wen=all ones, ram_d=background.
  - For a read/write pair, the read and write go to the same address in consecutive cycles.
- Cycle counts: 2^ADDR_WIDTH cycles each for E0 and E5, 2x that each for E1 through E4. Total 10x2^ADDR_WIDTH access cycles with no bubbles between elements.
- Compare pipeline:
  - Each read registers expected data and a compare-valid bit.
  - ram_q is compared against expected in the following cycle.
  - Any mismatch sets bist_fail (sticky). The run continues to the end; a failure does not abort it.
- DRAIN lasts exactly one cycle, for the final E5 read compare. ram_cen=1 during DRAIN.
- bist_done rises on the cycle after DRAIN, and bist_busy falls on the same edge.
- Address counter:
  - Loads 0 at up-element entry and all ones at down-element entry.
  - The terminal address (max or 0) triggers the element transition. No wrap-around access is ever issued.
- bist_start is ignored while in RUN or DRAIN. A start in the same cycle as DRAIN->DONE is also ignored.
- Reset mid-run: asynchronous return to IDLE with reset values. The SRAM contents afterwards are undefined.
- Outside RUN, the interface sits in the idle values listed under reset: ram_cen=1, ram_gwen=0, ram_wen=0.

Optional Feature:
AQ_SPSRAM_BIST_DIAG_EN
- Defined: adds outputs bist_fail_addr[ADDR_WIDTH], bist_fail_elem[3] and bist_fail_data[DATA_WIDTH]. These capture the address, element index (0-5) and ram_q of the first mismatch. They are held until the next accepted start, and read 0 when there has been no failure.
- Undefined: these ports and registers do not exist; only bist_fail is reported.

Decomposition:
- Package aq_spsram_bist_pkg holds:
  - FSM state encoding (IDLE/RUN/DRAIN/DONE)
  - element index constants E0-E5
  - per-element march table as constants: direction, read-expected background, write background, has_read, has_write
- Sub-module aq_spsram_bist_cmp: registered expected/valid pipeline, mismatch detection, sticky fail flag and optional diag capture.
- Address/element sequencing stays in the top module.

Test Plan:
- Fault-free run, 1-cycle-latency behavioural SRAM model, ADDR_WIDTH=3, pulse start -> bist_busy=1 for exactly 80+1 cycles, then bist_done=1, bist_fail=0, and the trace matches the March C- order.
- Stuck-at-1 on bit 5 at address 3 (ADDR_WIDTH=3) -> bist_fail=1 at done. With DIAG_EN: fail_addr=3, fail_elem=1, fail_data=0x00000020.
- Coupling fault: a write of 1 to address 6 flips bit 0 of address 2 -> bist_fail=1. With DIAG_EN: fail_elem=2, fail_addr=2, fail_data=0xFFFFFFFE.
- bist_start pulsed mid-run and on the DRAIN cycle -> both ignored; the total cycle count is unchanged.
- cpurst_b asserted during E3 -> outputs return to reset values immediately. A subsequent start runs a full, clean 80-cycle test.
- Default parameters (2048x32), fault-free -> done after 20480+1 busy cycles, fail=0. A second start from DONE clears done and reruns the test.
